mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares the data memory's port B between two requesters: requester 0 (VGA/display fetch) and requester 1 (I/O/DMA).
- Port A stays dedicated to the CPU.
- Arbitrates per cycle with round-robin plus a bounded burst, muxes the winner's address, data and write enable onto port B, and returns read data with a one-cycle valid strobe.
- Handles the memory's one-cycle registered, write-first read latency.

Parameters:
ADDR_W, 15, memory word-address width
DATA_W, 16, memory data width
MAX_BURST, 4, max consecutive accepted cycles for one owner while the other requester waits (>=1)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-high reset
req0  input  1  requester 0 wants an access this cycle
we0  input  1  requester 0 write (1) / read (0)
addr0  input  ADDR_W  requester 0 word address
wdata0  input  DATA_W  requester 0 write data
gnt0  output  1  combinational; access accepted this cycle when req0 & gnt0
rvalid0  output  1  registered; read data for requester 0 valid this cycle
req1, we1, addr1, wdata1, gnt1, rvalid1  same as requester 0, for requester 1
rdata  output  DATA_W  shared read data, wired from mem_dout
mem_addr  output  ADDR_W  to memory port B address
mem_din  output  DATA_W  to memory port B write data
mem_we  output  1  to memory port B write enable
mem_dout  input  DATA_W  from memory port B registered output

Behaviour:
- State:
  - owner in {NONE, R0, R1}
  - burst count, 0..MAX_BURST, saturating
  - last_served, 0 or 1
  - rvalid0/rvalid1 registers
- Reset, synchronous: owner=NONE, count=0, last_served=1 (R0 wins first tie), rvalid0=rvalid1=0.
- While reset is high: gnt0=gnt1=0, mem_we=0, mem_addr=0, mem_din=0.
- Grant decision, combinational each cycle from owner, count, req0 and req1:
  - owner=Ri, req_i=1, and (req_other=0 or count<MAX_BURST): grant Ri.
  - owner=Ri, req_i=1, req_other=1, count==MAX_BURST: grant the other requester.
  - owner=Ri, req_i=0: grant the other requester if it is requesting, else no grant.
  - owner=NONE, one request: grant it.
  - owner=NONE, both requesting: grant the requester that is not last_served.
- At most one grant is high. A grant is never high unless the matching req is high.
- Port B mux:
  - Granted requester's addr/wdata/we drive mem_addr/mem_din/mem_we.
  - No grant: mem_we=0, mem_addr=0, mem_din=0.
  - mem_we is never 1 without a grant.
- Register update at each clk edge (reset low):
  - owner <= granted requester, or NONE if no grant.
  - count <= 1 on an ownership change. count <= min(count+1, MAX_BURST) if the same owner is granted again. count <= 0 if no grant.
  - last_served <= granted index, only when a grant occurs.
  - rvalid_i <= gnt_i & req_i & ~we_i.
- Latency:
  - Read accepted in cycle t gives rvalid_i=1 in cycle t+1, with rdata = memory word at addr_i.
  - Back-to-back reads stream one word per cycle.
  - Writes produce no rvalid.
- Write then read of the same address on consecutive accepted cycles returns the new data; no hazard logic is needed here.
- Port A and port B writes to the same address in the same cycle: result undefined. Software avoids this; the arbiter does not check it.
- Only one rvalid is high per cycle. rdata is meaningful only when an rvalid is high.
- Reset mid-burst: the next cycle has no grant and rvalid0=rvalid1=0, even if a read was accepted in the cycle before reset.
- A requester must hold req, addr, we and wdata stable until it sees gnt. Dropping req before grant is legal; the request is simply withdrawn.

Decomposition:
- Shared package holds:
  - owner encoding constants OWN_NONE=2'd0, OWN_R0=2'd1, OWN_R1=2'd2
  - default ADDR_W and DATA_W matching the memory (15/16)
- One natural sub-module: mem_rr_select, the combinational grant logic (owner, count, last_served, req0, req1 -> gnt0, gnt1).
- Muxing, counters and rvalid registers stay in the top module.

Test Plan:
- Reset held 3 cycles with req0=req1=1 -> gnt0=gnt1=0, mem_we=0 throughout; first cycle after reset release: gnt0=1 (tie goes to R0).
- req0 only: write 16'hBEEF to 15'h0100, then read 15'h0100 on the next cycle -> gnt0 both cycles, rvalid0=1 one cycle after the read, rdata=16'hBEEF.
- req0 and req1 held high continuously, MAX_BURST=4 -> grant pattern 0,0,0,0,1,1,1,1,0,... and no cycle with both or neither granted.
- req1 alone reads 15'h7FFF for 10 cycles -> gnt1 every cycle (count saturates, no forced switch), rvalid1 on cycles 2..11, top address reached without wrap error.
- R0 owns with count=2, req0 drops while req1=1 -> gnt1 the same cycle; count=1 next cycle.
- Read accepted by R1, reset asserted the next cycle -> rvalid1=0 the cycle after reset, owner=NONE, last_served=1.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// rtl/mem_port_arbiter_pkg.sv - shared constants for the port B arbiter
package mem_port_arbiter_pkg;

    localparam int ADDR_W_DEF = 15;
    localparam int DATA_W_DEF = 16;

    localparam logic [1:0] OWN_NONE = 2'd0;
    localparam logic [1:0] OWN_R0   = 2'd1;
    localparam logic [1:0] OWN_R1   = 2'd2;

endpackage

// File: rtl/mem_rr_select.sv
// rtl/mem_rr_select.sv - combinational round-robin / bounded-burst grant select
module mem_rr_select
    import mem_port_arbiter_pkg::*;
#(
    parameter int MAX_BURST = 4,
    parameter int CNT_W     = $clog2(MAX_BURST + 1)
) (
    input  logic [1:0]       owner,
    input  logic [CNT_W-1:0] count,
    input  logic             last_served,
    input  logic             req0,
    input  logic             req1,
    output logic             gnt0,
    output logic             gnt1
);

    logic burst_open;

    assign burst_open = (count < CNT_W'(MAX_BURST));

    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        case (owner)
            OWN_R0: begin
                if (req0 && (!req1 || burst_open)) gnt0 = 1'b1;
                else if (req1)                     gnt1 = 1'b1;
            end
            OWN_R1: begin
                if (req1 && (!req0 || burst_open)) gnt1 = 1'b1;
                else if (req0)                     gnt0 = 1'b1;
            end
            default: begin
                // Idle tie goes to whoever was not served most recently.
                if (req0 && req1) begin
                    gnt0 = last_served;
                    gnt1 = !last_served;
                end else begin
                    gnt0 = req0;
                    gnt1 = req1;
                end
            end
        endcase
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares memory port B between display fetch and I/O/DMA
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W    = ADDR_W_DEF,
    parameter int DATA_W    = DATA_W_DEF,
    parameter int MAX_BURST = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0,
    input  logic              we0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    output logic              gnt0,
    output logic              rvalid0,
    input  logic              req1,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt1,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_din,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_dout
);

    localparam int CNT_W = $clog2(MAX_BURST + 1);

    logic [1:0]       owner;
    logic [CNT_W-1:0] count;
    logic             last_served;
    logic             sel0;
    logic             sel1;
    logic [CNT_W-1:0] count_next_same;

    mem_rr_select #(
        .MAX_BURST (MAX_BURST),
        .CNT_W     (CNT_W)
    ) u_select (
        .owner       (owner),
        .count       (count),
        .last_served (last_served),
        .req0        (req0),
        .req1        (req1),
        .gnt0        (sel0),
        .gnt1        (sel1)
    );

    // Grants are suppressed while reset is held so port B stays quiet.
    assign gnt0 = sel0 && !reset;
    assign gnt1 = sel1 && !reset;

    always_comb begin
        mem_addr = '0;
        mem_din  = '0;
        mem_we   = 1'b0;
        if (gnt0) begin
            mem_addr = addr0;
            mem_din  = wdata0;
            mem_we   = we0;
        end else if (gnt1) begin
            mem_addr = addr1;
            mem_din  = wdata1;
            mem_we   = we1;
        end
    end

    assign rdata = mem_dout;

    assign count_next_same = (count == CNT_W'(MAX_BURST)) ? count : count + 1'b1;

    always_ff @(posedge clk) begin
        if (reset) begin
            owner       <= OWN_NONE;
            count       <= '0;
            last_served <= 1'b1;
            rvalid0     <= 1'b0;
            rvalid1     <= 1'b0;
        end else begin
            if (gnt0) begin
                owner       <= OWN_R0;
                count       <= (owner == OWN_R0) ? count_next_same : CNT_W'(1);
                last_served <= 1'b0;
            end else if (gnt1) begin
                owner       <= OWN_R1;
                count       <= (owner == OWN_R1) ? count_next_same : CNT_W'(1);
                last_served <= 1'b1;
            end else begin
                owner <= OWN_NONE;
                count <= '0;
            end
            rvalid0 <= gnt0 && req0 && !we0;
            rvalid1 <= gnt1 && req1 && !we1;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        req0, we0, req1, we1;
    logic [14:0] addr0, addr1;
    logic [15:0] wdata0, wdata1;
    logic        gnt0, gnt1, rvalid0, rvalid1, mem_we;
    logic [15:0] rdata, mem_din, mem_dout;
    logic [14:0] mem_addr;
    logic [15:0] mem [0:32767];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mem_port_arbiter dut (
        .clk      (clk),
        .reset    (reset),
        .req0     (req0),
        .we0      (we0),
        .addr0    (addr0),
        .wdata0   (wdata0),
        .gnt0     (gnt0),
        .rvalid0  (rvalid0),
        .req1     (req1),
        .we1      (we1),
        .addr1    (addr1),
        .wdata1   (wdata1),
        .gnt1     (gnt1),
        .rvalid1  (rvalid1),
        .rdata    (rdata),
        .mem_addr (mem_addr),
        .mem_din  (mem_din),
        .mem_we   (mem_we),
        .mem_dout (mem_dout)
    );

    // Registered, write-first memory port B
    always @(posedge clk) begin
        if (mem_we) begin
            mem[mem_addr] <= mem_din;
            mem_dout      <= mem_din;
        end else begin
            mem_dout <= mem[mem_addr];
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    int pat [12] = '{0, 0, 0, 0, 1, 1, 1, 1, 0, 0, 0, 0};

    initial begin
        mem[15'h7FFF] = 16'h1234;
        reset = 1'b1;
        req0 = 1'b1; we0 = 1'b0; addr0 = 15'h0010; wdata0 = 16'h0;
        req1 = 1'b1; we1 = 1'b0; addr1 = 15'h0020; wdata1 = 16'h0;

        // Reset held 3 cycles with both requesting
        for (int i = 0; i < 3; i++) begin
            mid();
            chk("rst_gnt0", gnt0, 0);
            chk("rst_gnt1", gnt1, 0);
            chk("rst_we", mem_we, 0);
            chk("rst_addr", mem_addr, 0);
            next_cycle();
        end
        reset = 1'b0;

        // Continuous contention: bursts of 4
        for (int i = 0; i < 12; i++) begin
            mid();
            chk($sformatf("burst_g0_%0d", i), gnt0, (pat[i] == 0) ? 1 : 0);
            chk($sformatf("burst_g1_%0d", i), gnt1, (pat[i] == 1) ? 1 : 0);
            next_cycle();
        end

        // R0 alone: write then read back
        req1 = 1'b0;
        req0 = 1'b1; we0 = 1'b1; addr0 = 15'h0100; wdata0 = 16'hBEEF;
        mid();
        chk("wr_gnt0", gnt0, 1);
        chk("wr_mem_we", mem_we, 1);
        chk("wr_mem_addr", mem_addr, 32'h0100);
        chk("wr_mem_din", mem_din, 32'hBEEF);
        next_cycle();
        we0 = 1'b0;
        mid();
        chk("rd_gnt0", gnt0, 1);
        chk("rd_mem_we", mem_we, 0);
        chk("rd_no_rvalid_after_wr", rvalid0, 0);
        next_cycle();
        req0 = 1'b0;
        mid();
        chk("rd_rvalid0", rvalid0, 1);
        chk("rd_rvalid1", rvalid1, 0);
        chk("rd_rdata", rdata, 32'hBEEF);
        chk("idle_gnt0", gnt0, 0);
        chk("idle_mem_we", mem_we, 0);
        next_cycle();

        // R1 alone reads top address for 10 cycles
        req1 = 1'b1; we1 = 1'b0; addr1 = 15'h7FFF;
        for (int i = 1; i <= 11; i++) begin
            if (i == 11) req1 = 1'b0;
            mid();
            chk($sformatf("solo_gnt1_%0d", i), gnt1, (i <= 10) ? 1 : 0);
            chk($sformatf("solo_rv1_%0d", i), rvalid1, (i >= 2) ? 1 : 0);
            if (i >= 2) chk($sformatf("solo_rdata_%0d", i), rdata, 32'h1234);
            if (i <= 10) chk($sformatf("solo_addr_%0d", i), mem_addr, 32'h7FFF);
            next_cycle();
        end

        // R0 builds count=2, then drops while R1 waits
        req0 = 1'b1; we0 = 1'b0; addr0 = 15'h0200;
        mid();
        chk("drop_g0_a", gnt0, 1);
        next_cycle();
        req1 = 1'b1; addr1 = 15'h0300;
        mid();
        chk("drop_g0_b", gnt0, 1);
        chk("drop_g1_b", gnt1, 0);
        next_cycle();
        chk("drop_count2", dut.count, 2);
        req0 = 1'b0;
        mid();
        chk("drop_g1_same", gnt1, 1);
        chk("drop_g0_same", gnt0, 0);
        next_cycle();
        mid();
        chk("drop_count1", dut.count, 1);
        chk("drop_owner_r1", dut.owner, 2);
        next_cycle();

        // R1 read accepted, then reset
        req1 = 1'b1; we1 = 1'b0; addr1 = 15'h7FFF;
        mid();
        chk("rr_gnt1", gnt1, 1);
        next_cycle();
        reset = 1'b1;
        mid();
        chk("rr_rst_gnt1", gnt1, 0);
        next_cycle();
        mid();
        chk("rr_rvalid1", rvalid1, 0);
        chk("rr_rvalid0", rvalid0, 0);
        chk("rr_owner", dut.owner, 0);
        chk("rr_last", dut.last_served, 1);
        next_cycle();
        reset = 1'b0;
        req0 = 1'b1;
        mid();
        chk("rr_tie_g0", gnt0, 1);
        chk("rr_tie_g1", gnt1, 0);
        next_cycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
